axi_lite_xbar: RTL and testbench

AXI4-Lite 1-to-2 crossbar sitting directly upstream of the CLINT on the data-side bus. Takes the single LSU-side master port, decodes each transaction address, and routes it either to the CLINT slave or to the default memory/peripheral slave. Read and write directions are independent, with at most one outstanding transaction per direction. Routing adds zero cycles of latency.

---
 rtl/xbar_pkg.sv | 24 ++
 rtl/axi_lite_if.sv | 33 +++
 rtl/xbar_decode.sv | 14 +
 rtl/axi_lite_xbar.sv | 194 +++++++++++++++++++
 tb/tb_axi_lite_xbar.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/xbar_pkg.sv
// Shared types and default address window for the LSU-side AXI4-Lite crossbar.
package xbar_pkg;

  typedef enum logic {
    MEM,
    CLINT
  } xbar_sel_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } xbar_rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_ADDR,
    W_RESP
  } xbar_wr_state_t;

  localparam logic [31:0] CLINT_LO_DEF = 32'ha000_0048;
  localparam logic [31:0] CLINT_HI_DEF = 32'ha000_004f;

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite bundle (no prot/cache sideband) used on every crossbar port.
interface axi_lite_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/xbar_decode.sv
// Address decoder: inclusive unsigned window maps to CLINT, everything else to MEM.
module xbar_decode
  import xbar_pkg::*;
#(
  parameter logic [31:0] LO = CLINT_LO_DEF,
  parameter logic [31:0] HI = CLINT_HI_DEF
) (
  input  logic [31:0] addr,
  output xbar_sel_t   sel
);

  assign sel = (addr >= LO && addr <= HI) ? CLINT : MEM;

endmodule

// File: rtl/axi_lite_xbar.sv
// 1-to-2 AXI4-Lite crossbar (CLINT / default memory), zero-latency routing,
// one outstanding transaction per direction with independent read/write FSMs.
module axi_lite_xbar
  import xbar_pkg::*;
#(
  parameter logic [31:0] CLINT_LO = CLINT_LO_DEF,
  parameter logic [31:0] CLINT_HI = CLINT_HI_DEF
) (
  input logic        clk,
  input logic        reset_n,
  axi_lite_if.slave  up,
  axi_lite_if.master dn_clint,
  axi_lite_if.master dn_mem
);

  xbar_rd_state_t rd_state, rd_next;
  xbar_wr_state_t wr_state, wr_next;
  xbar_sel_t      ar_sel, aw_sel, rsel, rsel_next, wsel, wsel_next, wroute;

  logic c_arvalid, m_arvalid, u_arready, u_rvalid, c_rready, m_rready;
  logic c_awvalid, m_awvalid, u_awready, c_wvalid, m_wvalid, u_wready;
  logic u_bvalid, c_bready, m_bready;
  logic aw_en, w_en, b_en, aw_hs, w_hs;

  xbar_decode #(.LO(CLINT_LO), .HI(CLINT_HI)) u_ar_dec (.addr(up.araddr), .sel(ar_sel));
  xbar_decode #(.LO(CLINT_LO), .HI(CLINT_HI)) u_aw_dec (.addr(up.awaddr), .sel(aw_sel));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_state <= R_IDLE;
      wr_state <= W_IDLE;
      rsel     <= MEM;
      wsel     <= MEM;
    end else begin
      rd_state <= rd_next;
      wr_state <= wr_next;
      rsel     <= rsel_next;
      wsel     <= wsel_next;
    end
  end

  always_comb begin
    rd_next   = rd_state;
    rsel_next = rsel;
    c_arvalid = 1'b0;
    m_arvalid = 1'b0;
    u_arready = 1'b0;
    u_rvalid  = 1'b0;
    c_rready  = 1'b0;
    m_rready  = 1'b0;
    case (rd_state)
      R_IDLE: begin
        if (ar_sel == CLINT) begin
          c_arvalid = up.arvalid;
          u_arready = dn_clint.arready;
        end else begin
          m_arvalid = up.arvalid;
          u_arready = dn_mem.arready;
        end
        if (up.arvalid && u_arready) begin
          rd_next   = R_DATA;
          rsel_next = ar_sel;
        end
      end
      R_DATA: begin
        if (rsel == CLINT) begin
          u_rvalid = dn_clint.rvalid;
          c_rready = up.rready;
        end else begin
          u_rvalid = dn_mem.rvalid;
          m_rready = up.rready;
        end
        if (u_rvalid && up.rready) rd_next = R_IDLE;
      end
      default: rd_next = R_IDLE;
    endcase
    // Handshake signals must be quiet for the whole time reset is held.
    if (!reset_n) begin
      c_arvalid = 1'b0;
      m_arvalid = 1'b0;
      u_arready = 1'b0;
      u_rvalid  = 1'b0;
      c_rready  = 1'b0;
      m_rready  = 1'b0;
    end
  end

  always_comb begin
    wr_next   = wr_state;
    wsel_next = wsel;
    wroute    = (wr_state == W_IDLE) ? aw_sel : wsel;
    aw_en     = 1'b0;
    w_en      = 1'b0;
    b_en      = 1'b0;
    c_awvalid = 1'b0;
    m_awvalid = 1'b0;
    u_awready = 1'b0;
    c_wvalid  = 1'b0;
    m_wvalid  = 1'b0;
    u_wready  = 1'b0;
    u_bvalid  = 1'b0;
    c_bready  = 1'b0;
    m_bready  = 1'b0;
    case (wr_state)
      W_IDLE:  begin aw_en = 1'b1; w_en = up.awvalid; end
      W_DATA:  w_en = 1'b1;
      W_ADDR:  aw_en = 1'b1;
      default: b_en = 1'b1;
    endcase
    if (aw_en) begin
      if (wroute == CLINT) begin
        c_awvalid = up.awvalid;
        u_awready = dn_clint.awready;
      end else begin
        m_awvalid = up.awvalid;
        u_awready = dn_mem.awready;
      end
    end
    if (w_en) begin
      if (wroute == CLINT) begin
        c_wvalid = up.wvalid;
        u_wready = dn_clint.wready;
      end else begin
        m_wvalid = up.wvalid;
        u_wready = dn_mem.wready;
      end
    end
    if (b_en) begin
      if (wroute == CLINT) begin
        u_bvalid = dn_clint.bvalid;
        c_bready = up.bready;
      end else begin
        u_bvalid = dn_mem.bvalid;
        m_bready = up.bready;
      end
    end
    aw_hs = up.awvalid && u_awready;
    w_hs  = up.wvalid && u_wready;
    case (wr_state)
      W_IDLE: begin
        if (aw_hs || w_hs) begin
          wsel_next = aw_sel;
          if (aw_hs && w_hs) wr_next = W_RESP;
          else if (aw_hs)    wr_next = W_DATA;
          else               wr_next = W_ADDR;
        end
      end
      W_DATA:  if (w_hs) wr_next = W_RESP;
      W_ADDR:  if (aw_hs) wr_next = W_RESP;
      default: if (u_bvalid && up.bready) wr_next = W_IDLE;
    endcase
    if (!reset_n) begin
      c_awvalid = 1'b0;
      m_awvalid = 1'b0;
      u_awready = 1'b0;
      c_wvalid  = 1'b0;
      m_wvalid  = 1'b0;
      u_wready  = 1'b0;
      u_bvalid  = 1'b0;
      c_bready  = 1'b0;
      m_bready  = 1'b0;
    end
  end

  assign up.arready      = u_arready;
  assign up.rvalid       = u_rvalid;
  assign up.rdata        = (rsel == CLINT) ? dn_clint.rdata : dn_mem.rdata;
  assign up.rresp        = (rsel == CLINT) ? dn_clint.rresp : dn_mem.rresp;
  assign up.awready      = u_awready;
  assign up.wready       = u_wready;
  assign up.bvalid       = u_bvalid;
  assign up.bresp        = (wsel == CLINT) ? dn_clint.bresp : dn_mem.bresp;

  assign dn_clint.araddr  = up.araddr;
  assign dn_clint.arvalid = c_arvalid;
  assign dn_clint.rready  = c_rready;
  assign dn_clint.awaddr  = up.awaddr;
  assign dn_clint.awvalid = c_awvalid;
  assign dn_clint.wdata   = up.wdata;
  assign dn_clint.wstrb   = up.wstrb;
  assign dn_clint.wvalid  = c_wvalid;
  assign dn_clint.bready  = c_bready;

  assign dn_mem.araddr    = up.araddr;
  assign dn_mem.arvalid   = m_arvalid;
  assign dn_mem.rready    = m_rready;
  assign dn_mem.awaddr    = up.awaddr;
  assign dn_mem.awvalid   = m_awvalid;
  assign dn_mem.wdata     = up.wdata;
  assign dn_mem.wstrb     = up.wstrb;
  assign dn_mem.wvalid    = m_wvalid;
  assign dn_mem.bready    = m_bready;

endmodule

// File: tb/tb_axi_lite_xbar.sv
// Bench for axi_lite_xbar: the bench plays the LSU master and both slaves; routing
// expectations come from a plain address-window model.
module tb_axi_lite_xbar;
  localparam logic [31:0] LO = 32'ha000_0048;
  localparam logic [31:0] HI = 32'ha000_004f;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  axi_lite_if up_if ();
  axi_lite_if clint_if ();
  axi_lite_if mem_if ();

  axi_lite_xbar #(.CLINT_LO(LO), .CLINT_HI(HI)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .up      (up_if),
    .dn_clint(clint_if),
    .dn_mem  (mem_if)
  );

  always #5 clk = ~clk;

  function automatic bit is_clint(input logic [31:0] a);
    return (a >= LO) && (a <= HI);
  endfunction

  function automatic logic [14:0] vr_out();
    return {up_if.arready, up_if.rvalid, up_if.awready, up_if.wready, up_if.bvalid,
            clint_if.arvalid, clint_if.rready, clint_if.awvalid, clint_if.wvalid, clint_if.bready,
            mem_if.arvalid, mem_if.rready, mem_if.awvalid, mem_if.wvalid, mem_if.bready};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_all(input logic v);
    up_if.arvalid = v; up_if.rready = v; up_if.awvalid = v; up_if.wvalid = v; up_if.bready = v;
    up_if.araddr = 32'h0; up_if.awaddr = 32'h0; up_if.wdata = 32'h0; up_if.wstrb = 4'h0;
    clint_if.arready = v; clint_if.rvalid = v; clint_if.awready = v; clint_if.wready = v;
    clint_if.bvalid = v; clint_if.rdata = 32'h0; clint_if.rresp = 2'b00; clint_if.bresp = 2'b00;
    mem_if.arready = v; mem_if.rvalid = v; mem_if.awready = v; mem_if.wready = v;
    mem_if.bvalid = v; mem_if.rdata = 32'h0; mem_if.rresp = 2'b00; mem_if.bresp = 2'b00;
  endtask

  task automatic read_txn(input logic [31:0] addr, input int ar_wait, input int r_wait,
                          input logic [31:0] data, input logic [1:0] resp);
    bit c;
    logic tv, ov;
    c = is_clint(addr);
    up_if.araddr = addr; up_if.arvalid = 1'b1; up_if.rready = 1'b1;
    clint_if.rdata = c ? data : 32'hbad0_0001; clint_if.rresp = c ? resp : 2'b11;
    mem_if.rdata = c ? 32'hbad0_0002 : data; mem_if.rresp = c ? 2'b11 : resp;
    for (int i = 0; i <= ar_wait; i++) begin
      clint_if.arready = c ? (i == ar_wait) : 1'b1;
      mem_if.arready   = c ? 1'b1 : (i == ar_wait);
      clint_if.rvalid  = !c;
      mem_if.rvalid    = c;
      #1;
      tv = c ? clint_if.arvalid : mem_if.arvalid;
      ov = c ? mem_if.arvalid : clint_if.arvalid;
      n_checks++; if (tv !== 1'b1) begin n_fail++; $display("FAIL ar_route %h: tgt arvalid %b want 1", addr, tv); end
      n_checks++; if (ov !== 1'b0) begin n_fail++; $display("FAIL ar_cross %h: other arvalid %b want 0", addr, ov); end
      n_checks++; if (up_if.arready !== (i == ar_wait)) begin n_fail++; $display("FAIL ar_ready %h cyc %0d: got %b want %b", addr, i, up_if.arready, i == ar_wait); end
      n_checks++; if (up_if.rvalid !== 1'b0) begin n_fail++; $display("FAIL r_idle %h: up rvalid %b want 0", addr, up_if.rvalid); end
      n_checks++; if ((clint_if.rready | mem_if.rready) !== 1'b0) begin n_fail++; $display("FAIL rready_idle %h: got %b want 0", addr, clint_if.rready | mem_if.rready); end
      step();
    end
    up_if.arvalid = 1'b0;
    clint_if.arready = 1'b1; mem_if.arready = 1'b1;
    for (int i = 0; i <= r_wait; i++) begin
      clint_if.rvalid = c ? (i == r_wait) : 1'b1;
      mem_if.rvalid   = c ? 1'b1 : (i == r_wait);
      #1;
      tv = c ? clint_if.rready : mem_if.rready;
      ov = c ? mem_if.rready : clint_if.rready;
      n_checks++; if (up_if.arready !== 1'b0) begin n_fail++; $display("FAIL ar_blocked %h: up arready %b want 0", addr, up_if.arready); end
      n_checks++; if (up_if.rvalid !== (i == r_wait)) begin n_fail++; $display("FAIL r_valid %h cyc %0d: got %b want %b", addr, i, up_if.rvalid, i == r_wait); end
      n_checks++; if (tv !== 1'b1 || ov !== 1'b0) begin n_fail++; $display("FAIL r_ready_route %h: tgt %b other %b want 1/0", addr, tv, ov); end
      if (i == r_wait) begin
        n_checks++; if (up_if.rdata !== data || up_if.rresp !== resp) begin n_fail++; $display("FAIL r_data %h: got %h/%b want %h/%b", addr, up_if.rdata, up_if.rresp, data, resp); end
      end
      step();
    end
    drive_all(1'b0);
  endtask

  // mode 0: AW+W together; 1: AW first; 2: W first; 3: W accepted while AW stalls
  task automatic write_txn(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input logic [1:0] resp, input int mode, input int b_wait);
    bit c;
    logic tv, ov;
    c = is_clint(addr);
    up_if.awaddr = addr; up_if.wdata = data; up_if.wstrb = strb; up_if.bready = 1'b1;
    clint_if.awready = 1'b1; clint_if.wready = 1'b1; mem_if.awready = 1'b1; mem_if.wready = 1'b1;
    clint_if.bvalid = !c; clint_if.bresp = c ? resp : 2'b11;
    mem_if.bvalid = c; mem_if.bresp = c ? 2'b11 : resp;
    if (mode == 2) begin
      up_if.wvalid = 1'b1; up_if.awvalid = 1'b0;
      #1;
      n_checks++; if (up_if.wready !== 1'b0 || clint_if.wvalid !== 1'b0 || mem_if.wvalid !== 1'b0) begin n_fail++; $display("FAIL w_before_aw %h: wready %b wvalid %b/%b want 0", addr, up_if.wready, clint_if.wvalid, mem_if.wvalid); end
      step();
    end
    if (mode == 1) begin
      up_if.awvalid = 1'b1; up_if.wvalid = 1'b0;
      #1;
      tv = c ? clint_if.awvalid : mem_if.awvalid;
      ov = c ? mem_if.awvalid : clint_if.awvalid;
      n_checks++; if (tv !== 1'b1 || ov !== 1'b0 || up_if.awready !== 1'b1) begin n_fail++; $display("FAIL aw_first %h: tgt %b other %b awready %b want 1/0/1", addr, tv, ov, up_if.awready); end
      step();
      up_if.awvalid = 1'b0; up_if.wvalid = 1'b1;
      #1;
      tv = c ? clint_if.wvalid : mem_if.wvalid;
      ov = c ? mem_if.wvalid : clint_if.wvalid;
      n_checks++; if (tv !== 1'b1 || ov !== 1'b0 || up_if.wready !== 1'b1) begin n_fail++; $display("FAIL w_data_state %h: tgt %b other %b wready %b want 1/0/1", addr, tv, ov, up_if.wready); end
      step();
    end else if (mode == 3) begin
      up_if.awvalid = 1'b1; up_if.wvalid = 1'b1;
      if (c) clint_if.awready = 1'b0; else mem_if.awready = 1'b0;
      #1;
      tv = c ? clint_if.wvalid : mem_if.wvalid;
      n_checks++; if (up_if.awready !== 1'b0 || up_if.wready !== 1'b1 || tv !== 1'b1) begin n_fail++; $display("FAIL w_alone %h: awready %b wready %b tgt wvalid %b want 0/1/1", addr, up_if.awready, up_if.wready, tv); end
      step();
      up_if.wvalid = 1'b0;
      up_if.awaddr = c ? 32'h8000_0100 : LO;
      clint_if.awready = 1'b1; mem_if.awready = 1'b1;
      #1;
      tv = c ? clint_if.awvalid : mem_if.awvalid;
      ov = c ? mem_if.awvalid : clint_if.awvalid;
      n_checks++; if (tv !== 1'b1 || ov !== 1'b0 || up_if.awready !== 1'b1) begin n_fail++; $display("FAIL w_addr_state %h: tgt %b other %b awready %b want 1/0/1", addr, tv, ov, up_if.awready); end
      step();
    end else begin
      up_if.awvalid = 1'b1; up_if.wvalid = 1'b1;
      #1;
      tv = c ? (clint_if.awvalid & clint_if.wvalid) : (mem_if.awvalid & mem_if.wvalid);
      ov = c ? (mem_if.awvalid | mem_if.wvalid) : (clint_if.awvalid | clint_if.wvalid);
      n_checks++; if (tv !== 1'b1 || ov !== 1'b0) begin n_fail++; $display("FAIL aw_w_route %h: tgt %b other %b want 1/0", addr, tv, ov); end
      n_checks++; if (up_if.awready !== 1'b1 || up_if.wready !== 1'b1) begin n_fail++; $display("FAIL aw_w_ready %h: got %b%b want 11", addr, up_if.awready, up_if.wready); end
      n_checks++;
      if ((c ? clint_if.awaddr : mem_if.awaddr) !== addr || (c ? clint_if.wdata : mem_if.wdata) !== data
          || (c ? clint_if.wstrb : mem_if.wstrb) !== strb) begin
        n_fail++; $display("FAIL w_payload %h: data %h strb %h want %h %h", addr, c ? clint_if.wdata : mem_if.wdata, c ? clint_if.wstrb : mem_if.wstrb, data, strb);
      end
      step();
    end
    up_if.awvalid = 1'b0; up_if.wvalid = 1'b0;
    for (int i = 0; i <= b_wait; i++) begin
      clint_if.bvalid = c ? (i == b_wait) : 1'b1;
      mem_if.bvalid   = c ? 1'b1 : (i == b_wait);
      #1;
      tv = c ? clint_if.bready : mem_if.bready;
      ov = c ? mem_if.bready : clint_if.bready;
      n_checks++; if (up_if.bvalid !== (i == b_wait)) begin n_fail++; $display("FAIL b_valid %h cyc %0d: got %b want %b", addr, i, up_if.bvalid, i == b_wait); end
      n_checks++; if (tv !== 1'b1 || ov !== 1'b0 || up_if.awready !== 1'b0) begin n_fail++; $display("FAIL b_route %h: tgt %b other %b awready %b want 1/0/0", addr, tv, ov, up_if.awready); end
      if (i == b_wait) begin
        n_checks++; if (up_if.bresp !== resp) begin n_fail++; $display("FAIL b_resp %h: got %b want %b", addr, up_if.bresp, resp); end
      end
      step();
    end
    up_if.bready = 1'b0; up_if.awaddr = 32'h0; up_if.wdata = 32'h0; up_if.wstrb = 4'h0;
    clint_if.awready = 1'b0; clint_if.wready = 1'b0; clint_if.bvalid = 1'b0; clint_if.bresp = 2'b00;
    mem_if.awready = 1'b0; mem_if.wready = 1'b0; mem_if.bvalid = 1'b0; mem_if.bresp = 2'b00;
  endtask

  task automatic test_reset();
    drive_all(1'b1);
    #1;
    n_checks++; if (vr_out() !== 15'h0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", vr_out()); end
    step();
    n_checks++; if (vr_out() !== 15'h0) begin n_fail++; $display("FAIL reset_held: got %h want 0", vr_out()); end
    drive_all(1'b0);
    reset_n = 1'b1;
    step();
    n_checks++; if (vr_out() !== 15'h0) begin n_fail++; $display("FAIL post_reset_idle: got %h want 0", vr_out()); end
  endtask

  task automatic test_read_clint();
    read_txn(32'ha000_0048, 0, 1, 32'h0000_0123, 2'b00);
  endtask

  task automatic test_read_edges();
    read_txn(32'ha000_0047, 0, 0, 32'h1111_0047, 2'b00);
    read_txn(32'ha000_004c, 0, 0, 32'h2222_004c, 2'b01);
    read_txn(32'ha000_004f, 1, 0, 32'h3333_004f, 2'b00);
    read_txn(32'ha000_0050, 0, 0, 32'h4444_0050, 2'b10);
  endtask

  task automatic test_write_order();
    write_txn(32'h8000_0000, 32'hdead_beef, 4'hf, 2'b00, 2, 0);
    write_txn(32'h8000_0008, 32'h1234_5678, 4'h3, 2'b00, 1, 1);
    write_txn(32'ha000_0048, 32'h0000_00aa, 4'h1, 2'b10, 0, 0);
    write_txn(32'ha000_004c, 32'h0000_00bb, 4'hc, 2'b00, 3, 1);
  endtask

  task automatic test_concurrent();
    up_if.araddr = 32'ha000_004c; up_if.arvalid = 1'b1; clint_if.arready = 1'b1;
    #1;
    n_checks++; if (up_if.arready !== 1'b1 || clint_if.arvalid !== 1'b1 || mem_if.arvalid !== 1'b0) begin n_fail++; $display("FAIL conc_ar: arready %b clint %b mem %b want 1/1/0", up_if.arready, clint_if.arvalid, mem_if.arvalid); end
    step();
    up_if.arvalid = 1'b0; clint_if.arready = 1'b0; up_if.rready = 1'b0;
    clint_if.rvalid = 1'b1; clint_if.rdata = 32'h5555_aaaa; clint_if.rresp = 2'b01;
    mem_if.rdata = 32'hbad0_0003; mem_if.rresp = 2'b11;
    write_txn(32'h8000_0010, 32'hcafe_f00d, 4'hf, 2'b00, 0, 2);
    step();
    n_checks++; if (up_if.rvalid !== 1'b1 || up_if.rdata !== 32'h5555_aaaa || up_if.rresp !== 2'b01) begin n_fail++; $display("FAIL conc_r_held: %b %h %b want 1 5555aaaa 01", up_if.rvalid, up_if.rdata, up_if.rresp); end
    n_checks++; if (clint_if.rready !== 1'b0 || mem_if.rready !== 1'b0) begin n_fail++; $display("FAIL conc_rready_low: %b/%b want 0/0", clint_if.rready, mem_if.rready); end
    up_if.rready = 1'b1;
    #1;
    n_checks++; if (clint_if.rready !== 1'b1 || mem_if.rready !== 1'b0) begin n_fail++; $display("FAIL conc_rready: %b/%b want 1/0", clint_if.rready, mem_if.rready); end
    step();
    n_checks++; if (up_if.rvalid !== 1'b0) begin n_fail++; $display("FAIL conc_r_done: rvalid %b want 0", up_if.rvalid); end
    drive_all(1'b0);
  endtask

  task automatic test_backpressure();
    read_txn(32'h8000_0000, 3, 0, 32'h7777_0000, 2'b00);
  endtask

  task automatic test_reset_mid_read();
    up_if.araddr = 32'h8000_0020; up_if.arvalid = 1'b1; mem_if.arready = 1'b1;
    step();
    drive_all(1'b0);
    up_if.rready = 1'b1;
    #2;
    reset_n = 1'b0;
    drive_all(1'b1);
    #1;
    n_checks++; if (vr_out() !== 15'h0) begin n_fail++; $display("FAIL reset_mid_read: got %h want 0", vr_out()); end
    step();
    drive_all(1'b0);
    reset_n = 1'b1;
    mem_if.rvalid = 1'b1; up_if.rready = 1'b1;
    #1;
    n_checks++; if (up_if.rvalid !== 1'b0 || mem_if.rready !== 1'b0) begin n_fail++; $display("FAIL reset_dropped: rvalid %b rready %b want 0/0", up_if.rvalid, mem_if.rready); end
    step();
    drive_all(1'b0);
    read_txn(32'h8000_0004, 0, 1, 32'h0bad_cafe, 2'b00);
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int k = 0; k < 24; k++) begin
      case ($urandom_range(0, 3))
        0: a = LO + 32'($urandom_range(0, 7));
        1: a = LO - 32'd1 - 32'($urandom_range(0, 3));
        2: a = HI + 32'd1 + 32'($urandom_range(0, 3));
        default: a = $urandom;
      endcase
      if (k % 2 == 0)
        read_txn(a, $urandom_range(0, 2), $urandom_range(0, 2), $urandom, 2'($urandom_range(0, 3)));
      else
        write_txn(a, $urandom, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                  $urandom_range(0, 3), $urandom_range(0, 2));
    end
  endtask

  initial begin
    drive_all(1'b0);
    test_reset();
    test_read_clint();
    test_read_edges();
    test_write_order();
    test_concurrent();
    test_backpressure();
    test_reset_mid_read();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
